// File: rtl/bubble_sort_ctrl.sv
// In-place bubble sort sequencer with early exit, driving a 32x32 register file
// that has one cycle of read latency.
module bubble_sort_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  swap_count,
    output logic [ADDR_W-1:0] rf_addr,
    output logic              rf_we,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic [DATA_W-1:0] rf_rdata
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD_A = 3'd1;
    localparam logic [2:0] S_RD_B = 3'd2;
    localparam logic [2:0] S_CMP  = 3'd3;
    localparam logic [2:0] S_WR_A = 3'd4;
    localparam logic [2:0] S_WR_B = 3'd5;
    localparam logic [2:0] S_NEXT = 3'd6;
    localparam logic [2:0] S_DONE = 3'd7;

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    logic [2:0]        state;
    logic [ADDR_W-1:0] i;
    logic [ADDR_W:0]   limit;
    logic              swapped;
    logic [DATA_W-1:0] a_reg;

    logic [ADDR_W:0]   len_clamped;
    logic [ADDR_W-1:0] i_plus1;
    logic [ADDR_W:0]   i_plus2;

    assign len_clamped = (len > DEPTH) ? DEPTH : len;
    assign i_plus1     = i + ADDR_W'(1);
    assign i_plus2     = {1'b0, i} + (ADDR_W+1)'(2);

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    // rf_addr/rf_we/rf_wdata are loaded on entry to a state so they are stable
    // for the whole cycle of that state; the element b is held in rf_wdata.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            i          <= '0;
            limit      <= '0;
            swapped    <= 1'b0;
            a_reg      <= '0;
            swap_count <= '0;
            rf_addr    <= '0;
            rf_we      <= 1'b0;
            rf_wdata   <= '0;
        end else begin
            rf_we <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        limit      <= len_clamped;
                        i          <= '0;
                        swapped    <= 1'b0;
                        swap_count <= '0;
                        rf_addr    <= '0;
                        state      <= (len_clamped < (ADDR_W+1)'(2)) ? S_DONE : S_RD_A;
                    end
                end
                S_RD_A: begin
                    rf_addr <= i_plus1;
                    state   <= S_RD_B;
                end
                S_RD_B: begin
                    a_reg <= rf_rdata;
                    state <= S_CMP;
                end
                S_CMP: begin
                    if (a_reg > rf_rdata) begin
                        rf_we    <= 1'b1;
                        rf_addr  <= i;
                        rf_wdata <= rf_rdata;
                        state    <= S_WR_A;
                    end else begin
                        state <= S_NEXT;
                    end
                end
                S_WR_A: begin
                    rf_we    <= 1'b1;
                    rf_addr  <= i_plus1;
                    rf_wdata <= a_reg;
                    state    <= S_WR_B;
                end
                S_WR_B: begin
                    swapped <= 1'b1;
                    if (swap_count != '1)
                        swap_count <= swap_count + CNT_W'(1);
                    state <= S_NEXT;
                end
                S_NEXT: begin
                    if (i_plus2 < limit) begin
                        i       <= i_plus1;
                        rf_addr <= i_plus1;
                        state   <= S_RD_A;
                    end else if (!swapped || limit == (ADDR_W+1)'(2)) begin
                        state <= S_DONE;
                    end else begin
                        limit   <= limit - (ADDR_W+1)'(1);
                        i       <= '0;
                        swapped <= 1'b0;
                        rf_addr <= '0;
                        state   <= S_RD_A;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bubble_sort_ctrl.sv
// Self-checking bench for bubble_sort_ctrl: behavioural register file, vector table,
// random sorts against an array-level bubble sort model, and reset/restart corners.
module tb_bubble_sort_ctrl;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int CNT_W  = 16;
    localparam int DEPTH  = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W:0]   len = '0;
    logic              busy, done, rf_we;
    logic [CNT_W-1:0]  swap_count;
    logic [ADDR_W-1:0] rf_addr;
    logic [DATA_W-1:0] rf_wdata;
    logic [DATA_W-1:0] rf_rdata;

    logic [DATA_W-1:0] mem     [DEPTH];
    logic [DATA_W-1:0] ref_mem [DEPTH];
    int ref_swaps, ref_cycles;
    int we_count = 0, oob_writes = 0, cur_len = 0;
    int total = 0, passed = 0;

    bubble_sort_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .busy(busy), .done(done), .swap_count(swap_count),
        .rf_addr(rf_addr), .rf_we(rf_we), .rf_wdata(rf_wdata), .rf_rdata(rf_rdata)
    );

    always #5 clk = ~clk;

    // Register file: registered read, write at end of cycle.
    always @(posedge clk) begin
        if (rf_we) begin
            mem[rf_addr] <= rf_wdata;
            we_count <= we_count + 1;
            if (int'(rf_addr) >= cur_len) oob_writes <= oob_writes + 1;
        end
        rf_rdata <= mem[rf_addr];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Array-level bubble sort with early exit; each compare costs 4 cycles, a swap 2 more,
    // plus the DONE cycle.
    task automatic model_sort(input int n);
        int lim;
        bit sw;
        logic [DATA_W-1:0] t;
        for (int k = 0; k < DEPTH; k++) ref_mem[k] = mem[k];
        ref_swaps = 0;
        ref_cycles = 1;
        if (n > DEPTH) n = DEPTH;
        if (n < 2) return;
        lim = n;
        forever begin
            sw = 0;
            for (int k = 0; k + 1 < lim; k++) begin
                ref_cycles += 4;
                if (ref_mem[k] > ref_mem[k+1]) begin
                    t = ref_mem[k]; ref_mem[k] = ref_mem[k+1]; ref_mem[k+1] = t;
                    ref_cycles += 2;
                    ref_swaps++;
                    sw = 1;
                end
            end
            if (!sw || lim == 2) break;
            lim--;
        end
    endtask

    task automatic run_sort(input int n, input bit inject, input string tag,
                            input int exp_cycles, input int exp_swaps);
        int k, busy_low, bad;
        bit seen;
        cur_len = (n > DEPTH) ? DEPTH : n;
        we_count = 0;
        oob_writes = 0;
        @(negedge clk);
        len = n[ADDR_W:0];
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        seen = 0; busy_low = 0; k = 0;
        while (k < 8000 && !seen) begin
            @(negedge clk);
            k++;
            if (done) seen = 1;
            else begin
                if (!busy) busy_low++;
                start = inject && (k % 100 == 50) && (k + 4 < exp_cycles);
            end
        end
        start = 1'b0;
        check({tag, " done_seen"}, 64'(seen), 64'd1);
        check({tag, " done_latency"}, 64'(k), 64'(exp_cycles));
        check({tag, " busy_during"}, 64'(busy_low), 64'd0);
        check({tag, " busy_at_done"}, 64'(busy), 64'd1);
        check({tag, " swap_count"}, 64'(swap_count), 64'(exp_swaps));
        check({tag, " we_cycles"}, 64'(we_count), 64'(2 * exp_swaps));
        check({tag, " oob_writes"}, 64'(oob_writes), 64'd0);
        bad = 0;
        for (int j = 0; j < DEPTH; j++) if (mem[j] !== ref_mem[j]) bad++;
        check({tag, " mem_mismatches"}, 64'(bad), 64'd0);
        @(negedge clk);
        check({tag, " busy_after"}, 64'(busy), 64'd0);
        check({tag, " done_pulse_width"}, 64'(done), 64'd0);
    endtask

    function automatic logic [3:0][31:0] pack4(input logic [31:0] a0, a1, a2, a3);
        logic [3:0][31:0] r;
        r[0] = a0; r[1] = a1; r[2] = a2; r[3] = a3;
        return r;
    endfunction

    typedef struct packed {
        logic [5:0]       n;
        logic [3:0][31:0] init;
        logic [3:0][31:0] exp;
        logic [15:0]      swaps;
        logic [15:0]      cycles;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int n, hit, extra_done;
        logic prev_we;
        logic [3:0] dpat;

        vecs[0] = '{6'd4, pack4(1, 2, 3, 4), pack4(1, 2, 3, 4), 16'd0, 16'd13};
        vecs[1] = '{6'd4, pack4(4, 3, 2, 1), pack4(1, 2, 3, 4), 16'd6, 16'd37};
        vecs[2] = '{6'd4, pack4(32'hFFFF_FFFF, 0, 5, 5), pack4(0, 5, 5, 32'hFFFF_FFFF), 16'd3, 16'd27};
        vecs[3] = '{6'd0, pack4(7, 3, 9, 1), pack4(7, 3, 9, 1), 16'd0, 16'd1};
        vecs[4] = '{6'd1, pack4(7, 3, 9, 1), pack4(7, 3, 9, 1), 16'd0, 16'd1};
        vecs[5] = '{6'd2, pack4(9, 3, 1, 0), pack4(3, 9, 1, 0), 16'd1, 16'd7};
        vecs[6] = '{6'd3, pack4(2, 1, 3, 0), pack4(1, 2, 3, 0), 16'd1, 16'd15};

        for (int k = 0; k < DEPTH; k++) mem[k] = 32'hA500_0000 + k;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset swap_count", 64'(swap_count), 64'd0);
        check("reset rf_addr", 64'(rf_addr), 64'd0);
        check("reset rf_we", 64'(rf_we), 64'd0);
        check("reset rf_wdata", 64'(rf_wdata), 64'd0);
        rst = 1'b1;

        for (int v = 0; v < 7; v++) begin
            for (int k = 0; k < DEPTH; k++) mem[k] = 32'hA500_0000 + k;
            for (int k = 0; k < 4; k++) mem[k] = vecs[v].init[k];
            for (int k = 0; k < DEPTH; k++) ref_mem[k] = mem[k];
            for (int k = 0; k < 4; k++) ref_mem[k] = vecs[v].exp[k];
            run_sort(int'(vecs[v].n), 1'b0, $sformatf("vec%0d", v),
                     int'(vecs[v].cycles), int'(vecs[v].swaps));
        end

        // Start held high across a degenerate sort: accepted in IDLE, ignored in DONE,
        // accepted again in the IDLE cycle that follows.
        @(negedge clk);
        len = '0;
        start = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(posedge clk);
            if (j == 2) #1 start = 1'b0;
            @(negedge clk);
            dpat[j] = done;
        end
        check("back_to_back done pattern", 64'(dpat), 64'b0101);

        for (int k = 0; k < DEPTH; k++) mem[k] = 31 - k;
        model_sort(32);
        run_sort(32, 1'b1, "full", ref_cycles, 496);

        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(0, 40);
            for (int k = 0; k < DEPTH; k++) mem[k] = $urandom_range(0, 15);
            model_sort(n);
            run_sort(n, 1'b0, $sformatf("rand%0d_len%0d", r, n), ref_cycles, ref_swaps);
        end

        // Reset during a WR_B cycle (second of a pair of write cycles).
        for (int k = 0; k < DEPTH; k++) mem[k] = (k < 8) ? 8 - k : 32'hA500_0000 + k;
        cur_len = 8;
        @(negedge clk);
        len = 6'd8;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        hit = 0;
        prev_we = 1'b0;
        for (int k = 0; k < 500 && hit == 0; k++) begin
            @(negedge clk);
            if (rf_we && prev_we) hit = 1;
            prev_we = rf_we;
        end
        check("midreset found WR_B", 64'(hit), 64'd1);
        rst = 1'b0;
        @(negedge clk);
        check("midreset busy", 64'(busy), 64'd0);
        check("midreset done", 64'(done), 64'd0);
        check("midreset swap_count", 64'(swap_count), 64'd0);
        check("midreset rf_addr", 64'(rf_addr), 64'd0);
        check("midreset rf_we", 64'(rf_we), 64'd0);
        check("midreset rf_wdata", 64'(rf_wdata), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        extra_done = 0;
        repeat (6) begin
            @(negedge clk);
            if (done || busy) extra_done++;
        end
        check("midreset no done/busy after", 64'(extra_done), 64'd0);
        model_sort(8);
        run_sort(8, 1'b0, "after_reset", ref_cycles, ref_swaps);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
